mc_state_register: RTL and testbench

Sequential half of the multicycle CPU controller. It holds the 4-bit control state and latches the opcode. It drives the Moore-decoded datapath control signals. It stalls memory states on a ready handshake, traps illegal opcodes and counts retired instructions. It sits directly downstream of the next-state logic: that logic's `next_state` feeds this block, and this block's `current_state` and `opcode` feed back into it.

---
 rtl/mc_state_register_if.sv | 60 ++++++
 rtl/mc_state_register.sv | 200 ++++++++++++++++++++
 tb/tb_mc_state_register.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mc_state_register_if.sv
// mc_state_register_if
//   Bundles everything the multicycle-controller state register exchanges with
//   the next-state logic, the memory port and the datapath.
//
//   Modports:
//     slave  - the state register itself (mc_state_register)
//     master - the surrounding controller/datapath/memory model
//
//   Signals:
//     next_state    in  4   proposed state from the next-state logic
//     mem_ready     in  1   memory completes the current access this cycle
//     mem_data      in  32  memory read data, [31:26] = opcode
//     current_state out 4   registered control state
//     opcode        out 6   latched opcode of the executing instruction
//     pc_write .. alu_src_a out 1 each, datapath enables/selects
//     alu_src_b     out 2   00 B, 01 const 4, 10 sext imm, 11 imm<<2
//     alu_op        out 2   00 add, 01 sub, 10 funct, 11 lui
//     pc_source     out 2   00 ALU, 01 ALUOut, 10 jump target
//     illegal       out 1   sticky illegal-opcode flag
//     retired       out CNT_W retired-instruction count
interface mc_state_register_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       next_state;
  logic             mem_ready;
  logic [31:0]      mem_data;
  logic [3:0]       current_state;
  logic [5:0]       opcode;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  next_state, mem_ready, mem_data,
    output current_state, opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
    output pc_source, illegal, retired
  );

  modport master (
    output next_state, mem_ready, mem_data,
    input  current_state, opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
    input  pc_source, illegal, retired
  );
endinterface

// File: rtl/mc_state_register.sv
// mc_state_register
//   Sequential half of the multicycle CPU controller: holds the control state,
//   latches the opcode at fetch, Moore-decodes the datapath controls, stalls
//   memory states on mem_ready, traps illegal opcodes and counts retirements.
//
//   Ports:
//     clk  in  system clock, rising edge
//     rst  in  asynchronous active-high reset
//     bus  slave modport of mc_state_register_if (see interface header)
//
//   state | meaning
//   ------+-------------------------------------------
//     0   | FETCH   - read instruction, PC += 4
//     1   | DECODE  - register read, branch target
//     2   | MEMADDR - lw/sw address compute
//     3   | MEMRD   - data memory read
//     4   | LDWB    - load writeback
//     5   | MEMWR   - data memory write
//     6   | REXEC   - R-type execute
//     7   | RWB     - R-type writeback
//     8   | BEQ     - branch compare
//     9   | JUMP    - jump
//    10   | IWB     - immediate writeback
//    11   | LUIEX   - lui execute
//    12   | ADDIEX  - addi execute
//   13,14 | unused, recover to FETCH
//    15   | TRAP    - illegal opcode, all controls off
module mc_state_register #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  mc_state_register_if.slave bus
);

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADDR = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_LDWB    = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_REXEC   = 4'd6,
    ST_RWB     = 4'd7,
    ST_BEQ     = 4'd8,
    ST_JUMP    = 4'd9,
    ST_IWB     = 4'd10,
    ST_LUIEX   = 4'd11,
    ST_ADDIEX  = 4'd12,
    ST_UNUSED0 = 4'd13,
    ST_UNUSED1 = 4'd14,
    ST_TRAP    = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             legal_op;
  logic             mem_state;
  logic             retire_src;

  always_comb begin
    legal_op = 1'b0;
    case (opcode_q)
      6'd0, 6'd2, 6'd4, 6'd8, 6'd15, 6'd35, 6'd43: legal_op = 1'b1;
      default:                                      legal_op = 1'b0;
    endcase
  end

  assign mem_state  = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                      (state_q == ST_MEMWR);
  assign retire_src = (state_q == ST_LDWB) || (state_q == ST_MEMWR) ||
                      (state_q == ST_RWB)  || (state_q == ST_BEQ)   ||
                      (state_q == ST_JUMP) || (state_q == ST_IWB);

  always_comb begin
    state_d   = state_e'(bus.next_state);
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    retired_d = retired_q;

    // Stall first so an unfinished access can never be skipped.
    if (mem_state && !bus.mem_ready) begin
      state_d = state_q;
    end else if (state_q == ST_DECODE && !legal_op) begin
      state_d = ST_TRAP;
    end else if (state_q == ST_UNUSED0 || state_q == ST_UNUSED1) begin
      state_d = ST_FETCH;
    end

    if (state_q == ST_FETCH && bus.mem_ready) begin
      opcode_d = bus.mem_data[31:26];
    end

    if (state_d == ST_TRAP) begin
      illegal_d = 1'b1;
    end

    // TRAP and the unused states are not in retire_src, so they never count.
    if (retire_src && state_d == ST_FETCH) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 6'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Moore decode; rst gates everything so no enable leaks while in reset.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;

    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        ST_DECODE: begin
          bus.alu_src_b = 2'b11;
        end
        ST_MEMADDR, ST_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        ST_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        ST_LDWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        ST_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        ST_REXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        ST_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        ST_BEQ: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
        end
        ST_JUMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
        ST_IWB: begin
          bus.reg_write = 1'b1;
        end
        ST_LUIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b11;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.current_state = state_q;
  assign bus.opcode        = opcode_q;
  assign bus.illegal       = illegal_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_mc_state_register.sv
module tb_mc_state_register;

  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mc_state_register_if #(.CNT_W(16)) b16 ();
  mc_state_register_if #(.CNT_W(4))  b4 ();

  mc_state_register #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b16));
  mc_state_register #(.CNT_W(4))  dut_w4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [5:0]  op;
    logic        ill;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  logic [5:0]  exp_op;
  logic        exp_ill;
  logic [15:0] exp_ret;
  logic [3:0]  prev_s;
  logic        prev_rdy;
  logic [31:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] decode(input logic [3:0] s, input logic rdy);
    logic pcw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa;
    logic [1:0] sb, aop, psrc;
    {pcw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      4'd0:        begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:        sb = 2'b11;
      4'd2, 4'd12: begin sa = 1; sb = 2'b10; end
      4'd3:        begin mr = 1; iod = 1; end
      4'd4:        begin rw = 1; m2r = 1; end
      4'd5:        begin mw = 1; iod = 1; end
      4'd6:        begin sa = 1; aop = 2'b10; end
      4'd7:        begin rw = 1; rd = 1; end
      4'd8:        begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:        begin pcw = 1; psrc = 2'b10; end
      4'd10:       rw = 1;
      4'd11:       begin sa = 1; sb = 2'b10; aop = 2'b11; end
      default:     ;
    endcase
    return {pcw, pwc, iod, mr, mw, irw, m2r, rw, rd, sa, sb, aop, psrc};
  endfunction

  function automatic logic [31:0] instr(input logic [5:0] op);
    return {op, 26'h2AA_AAAA};
  endfunction

  function automatic logic [15:0] act_ctrl16();
    return {b16.pc_write, b16.pc_write_cond, b16.i_or_d, b16.mem_read,
            b16.mem_write, b16.ir_write, b16.mem_to_reg, b16.reg_write,
            b16.reg_dst, b16.alu_src_a, b16.alu_src_b, b16.alu_op, b16.pc_source};
  endfunction

  task automatic drive(input logic [3:0] ns, input logic rdy, input logic [31:0] data);
    b16.next_state = ns;  b4.next_state = ns;
    b16.mem_ready  = rdy; b4.mem_ready  = rdy;
    b16.mem_data   = data; b4.mem_data  = data;
  endtask

  task automatic clear_model();
    exp_op = 6'd0; exp_ill = 1'b0; exp_ret = 16'd0;
    prev_s = 4'd0; prev_rdy = 1'b0; prev_data = 32'd0;
  endtask

  // One cycle: s is the hand-computed state expected after this edge.
  task automatic step(input logic [3:0] s, input logic [3:0] ns, input logic rdy,
                      input logic [31:0] data);
    exp_t e;
    @(posedge clk);
    #1;
    if (prev_s == 4'd0 && prev_rdy) exp_op = prev_data[31:26];
    if (s == 4'd0 && (prev_s inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10})) exp_ret++;
    if (s == 4'd15) exp_ill = 1'b1;
    drive(ns, rdy, data);
    e.st = s; e.ctrl = decode(s, rdy); e.op = exp_op; e.ill = exp_ill; e.ret = exp_ret;
    q.push_back(e);
    prev_s = s; prev_rdy = rdy; prev_data = data;
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state",   {28'd0, b16.current_state}, {28'd0, e.st});
        check("ctrl",    {16'd0, act_ctrl16()},       {16'd0, e.ctrl});
        check("opcode",  {26'd0, b16.opcode},         {26'd0, e.op});
        check("illegal", {31'd0, b16.illegal},        {31'd0, e.ill});
        check("retired", {16'd0, b16.retired},        {16'd0, e.ret});
        check("retired_w4", {28'd0, b4.retired},      {28'd0, e.ret[3:0]});
      end
    end
  end

  initial begin
    clear_model();
    drive(4'd1, 1'b0, GARB);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",    {28'd0, b16.current_state}, 32'd0);
    check("rst_opcode",   {26'd0, b16.opcode},        32'd0);
    check("rst_illegal",  {31'd0, b16.illegal},       32'd0);
    check("rst_retired",  {16'd0, b16.retired},       32'd0);
    check("rst_mem_read", {31'd0, b16.mem_read},      32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_mem_read", {31'd0, b16.mem_read}, 32'd1);

    // lw: 2 fetch waits, 1 memrd wait; mem_ready in DECODE is ignored
    step(0, 1, 0, GARB);  step(0, 1, 0, GARB);  step(0, 1, 1, instr(6'd35));
    step(1, 2, 1, GARB);  step(2, 3, 0, GARB);  step(3, 4, 0, GARB);
    step(3, 4, 1, GARB);  step(4, 0, 0, GARB);
    // sw, zero wait states
    step(0, 1, 1, instr(6'd43)); step(1, 2, 0, GARB); step(2, 5, 0, GARB);
    step(5, 0, 1, GARB);
    // R-type then addi
    step(0, 1, 1, instr(6'd0));  step(1, 6, 0, GARB); step(6, 7, 1, GARB);
    step(7, 0, 0, GARB);
    step(0, 1, 1, instr(6'd8));  step(1, 12, 0, GARB); step(12, 10, 0, GARB);
    step(10, 0, 0, GARB);
    // illegal opcode: next_state says JUMP but trap must win
    step(0, 1, 1, instr(6'd63)); step(1, 9, 0, GARB); step(15, 0, 0, GARB);
    // j
    step(0, 1, 1, instr(6'd2));  step(1, 9, 0, GARB); step(9, 0, 0, GARB);
    // beq
    step(0, 1, 1, instr(6'd4));  step(1, 8, 0, GARB); step(8, 0, 0, GARB);
    // lui
    step(0, 1, 1, instr(6'd15)); step(1, 11, 0, GARB); step(11, 10, 0, GARB);
    step(10, 0, 0, GARB);
    // unused state recovers to FETCH regardless of next_state, no retire
    step(0, 1, 1, instr(6'd2));  step(1, 13, 0, GARB); step(13, 5, 0, GARB);
    // sw stalled in MEMWR, then async reset
    step(0, 1, 1, instr(6'd43)); step(1, 2, 0, GARB); step(2, 5, 0, GARB);
    step(5, 0, 0, GARB);
    @(posedge clk);
    #1;
    check("stall_state",     {28'd0, b16.current_state}, 32'd5);
    check("stall_mem_write", {31'd0, b16.mem_write},     32'd1);
    rst = 1'b1;
    #1;
    check("arst_mem_write", {31'd0, b16.mem_write},     32'd0);
    check("arst_state",     {28'd0, b16.current_state}, 32'd0);
    check("arst_opcode",    {26'd0, b16.opcode},        32'd0);
    check("arst_illegal",   {31'd0, b16.illegal},       32'd0);
    check("arst_retired",   {16'd0, b16.retired},       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    #1;
    check("rel_mem_read", {31'd0, b16.mem_read}, 32'd1);

    // 16 jumps: narrow counter wraps 15 -> 0
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 1, instr(6'd2)); step(1, 9, 0, GARB); step(9, 0, 0, GARB);
    end
    step(0, 1, 0, GARB);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
